// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling via a DIV-cycle divider,
// optional parity and 1/2 stop bits; one-cycle valid pulse per frame with error flags.
module uart_rx #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_valid,
  output logic                         o_user_rx_check_err,
  output logic                         o_user_rx_frame_err
);

  localparam int          LP_DIV       = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam logic [15:0] LP_DIV_M1    = 16'(LP_DIV - 1);
  localparam logic [15:0] LP_HALF_M1   = 16'(LP_DIV / 2 - 1);
  localparam logic [7:0]  LP_LAST_DATA = 8'(P_UART_DATA_WIDTH - 1);
  localparam logic [7:0]  LP_LAST_STOP = 8'(P_UART_STOP_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CHECK, S_STOP} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic                         r_rx_meta;
  logic                         r_rx_s;
  logic                         r_rx_d;
  logic [15:0]                  r_cnt_div;
  logic [7:0]                   r_cnt_bit;
  logic [P_UART_DATA_WIDTH-1:0] r_shift;
  logic                         r_check_err;
  logic                         r_frame_err;
  logic [P_UART_DATA_WIDTH-1:0] r_out_data;
  logic                         r_out_valid;
  logic                         r_out_check_err;
  logic                         r_out_frame_err;

  logic w_fall;
  logic w_tick;
  logic w_half;
  logic w_par_exp;

  assign w_fall    = r_rx_d & ~r_rx_s;
  assign w_tick    = (r_cnt_div == LP_DIV_M1);
  assign w_half    = (r_cnt_div == LP_HALF_M1);
  assign w_par_exp = (P_UART_CHECK == 2) ? ^r_shift : ~^r_shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) w_state_nxt = S_START;
      S_START: if (w_half) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (w_tick && r_cnt_bit == LP_LAST_DATA)
          w_state_nxt = (P_UART_CHECK > 0) ? S_CHECK : S_STOP;
      S_CHECK: if (w_tick) w_state_nxt = S_STOP;
      S_STOP:  if (w_tick && r_cnt_bit == LP_LAST_STOP) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_div       <= '0;
      r_cnt_bit       <= '0;
      r_shift         <= '0;
      r_check_err     <= 1'b0;
      r_frame_err     <= 1'b0;
      r_out_data      <= '0;
      r_out_valid     <= 1'b0;
      r_out_check_err <= 1'b0;
      r_out_frame_err <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt_div <= '0;
          r_cnt_bit <= '0;
          if (w_fall) begin
            r_check_err <= 1'b0;
            r_frame_err <= 1'b0;
          end
        end
        S_START: r_cnt_div <= w_half ? 16'd0 : r_cnt_div + 16'd1;
        S_DATA: begin
          if (w_tick) begin
            r_cnt_div <= '0;
            r_shift   <= {r_rx_s, r_shift[P_UART_DATA_WIDTH-1:1]};
            r_cnt_bit <= (r_cnt_bit == LP_LAST_DATA) ? 8'd0 : r_cnt_bit + 8'd1;
          end else begin
            r_cnt_div <= r_cnt_div + 16'd1;
          end
        end
        S_CHECK: begin
          if (w_tick) begin
            r_cnt_div   <= '0;
            r_check_err <= (r_rx_s != w_par_exp);
          end else begin
            r_cnt_div <= r_cnt_div + 16'd1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_cnt_div   <= '0;
            r_frame_err <= r_frame_err | ~r_rx_s;
            // Deliver at the last stop sample so a start edge right after is not missed.
            if (r_cnt_bit == LP_LAST_STOP) begin
              r_cnt_bit       <= '0;
              r_out_data      <= r_shift;
              r_out_valid     <= 1'b1;
              r_out_check_err <= r_check_err;
              r_out_frame_err <= r_frame_err | ~r_rx_s;
            end else begin
              r_cnt_bit <= r_cnt_bit + 8'd1;
            end
          end else begin
            r_cnt_div <= r_cnt_div + 16'd1;
          end
        end
        default: r_cnt_div <= '0;
      endcase
    end
  end

  assign o_user_rx_data      = r_out_data;
  assign o_user_rx_valid     = r_out_valid;
  assign o_user_rx_check_err = r_out_check_err;
  assign o_user_rx_frame_err = r_out_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (8N1, 8O1, 8E2) driven by a frame-level driver;
// expected words are queued at frame start and a negedge monitor pops and compares.
module tb_uart_rx;

  localparam int DIV  = 16;
  localparam int HALF = 8;

  typedef struct {
    logic [7:0] data;
    logic       cerr;
    logic       ferr;
    int         edge_n;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       line   [3];
  logic [7:0] rx_data[3];
  logic       rx_vld [3];
  logic       rx_cerr[3];
  logic       rx_ferr[3];

  int   checks;
  int   errors;
  int   edge_cnt;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  uart_rx #(.P_SYSTEM_CLK(1600), .P_UART_BUADRATE(100), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) dut_n (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(line[0]), .o_user_rx_data(rx_data[0]),
    .o_user_rx_valid(rx_vld[0]), .o_user_rx_check_err(rx_cerr[0]),
    .o_user_rx_frame_err(rx_ferr[0]));

  uart_rx #(.P_SYSTEM_CLK(1600), .P_UART_BUADRATE(100), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) dut_o (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(line[1]), .o_user_rx_data(rx_data[1]),
    .o_user_rx_valid(rx_vld[1]), .o_user_rx_check_err(rx_cerr[1]),
    .o_user_rx_frame_err(rx_ferr[1]));

  uart_rx #(.P_SYSTEM_CLK(1600), .P_UART_BUADRATE(100), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(2), .P_UART_CHECK(2)) dut_e (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(line[2]), .o_user_rx_data(rx_data[2]),
    .o_user_rx_valid(rx_vld[2]), .o_user_rx_check_err(rx_cerr[2]),
    .o_user_rx_frame_err(rx_ferr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int par_mode(input int id);
    return id;
  endfunction

  function automatic int nstop(input int id);
    return (id == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id, input exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Frame-level reference: parity error means the ones-count of data plus parity bit
  // has the wrong oddness; framing error means any stop bit driven low.
  task automatic drive_frame(input int id, input logic [7:0] d, input logic par,
                             input logic [1:0] stp);
    exp_t e;
    int   ones;
    int   np;
    np     = (par_mode(id) > 0) ? 1 : 0;
    ones   = $countones(d) + int'(par);
    e.data = d;
    e.cerr = (par_mode(id) == 1) ? (ones % 2 != 1) :
             (par_mode(id) == 2) ? (ones % 2 != 0) : 1'b0;
    e.ferr = (stp[0] == 1'b0) || (nstop(id) == 2 && stp[1] == 1'b0);
    line[id] = 1'b0;
    e.edge_n = edge_cnt + 3 + HALF + DIV * (8 + np + nstop(id));
    push_exp(id, e);
    wait_clks(DIV);
    for (int b = 0; b < 8; b++) begin
      line[id] = d[b];
      wait_clks(DIV);
    end
    if (np == 1) begin
      line[id] = par;
      wait_clks(DIV);
    end
    for (int s = 0; s < nstop(id); s++) begin
      line[id] = stp[s];
      wait_clks(DIV);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   got;
    for (int i = 0; i < 3; i++) begin
      if (rx_vld[i] === 1'b1) begin
        got = 1'b0;
        case (i)
          0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid dut%0d: valid with no frame expected, data %0h", i, rx_data[i]);
        end else begin
          chk($sformatf("data dut%0d", i), int'(rx_data[i]), int'(e.data));
          chk($sformatf("check_err dut%0d", i), int'(rx_cerr[i]), int'(e.cerr));
          chk($sformatf("frame_err dut%0d", i), int'(rx_ferr[i]), int'(e.ferr));
          chk($sformatf("valid_cycle dut%0d", i), edge_cnt, e.edge_n);
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       par;
    logic [1:0] stp;
    int         gap;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) line[i] = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_outputs dut%0d", i),
          int'({rx_data[i], rx_vld[i], rx_cerr[i], rx_ferr[i]}), 0);
    end
    wait_clks(5);

    drive_frame(0, 8'h55, 1'b0, 2'b11);
    wait_clks(10);
    drive_frame(0, 8'h80, 1'b0, 2'b11);
    drive_frame(0, 8'h01, 1'b0, 2'b11);
    wait_clks(10);

    drive_frame(1, 8'hA3, 1'b1, 2'b11);
    wait_clks(10);
    drive_frame(1, 8'hA3, 1'b0, 2'b11);
    wait_clks(10);

    drive_frame(2, 8'h07, 1'b1, 2'b11);
    wait_clks(10);

    // Stop bit low, then line held low: exactly one errored frame.
    drive_frame(0, 8'h3C, 1'b0, 2'b10);
    wait_clks(40);
    line[0] = 1'b1;
    wait_clks(20);

    line[0] = 1'b0;
    wait_clks(5);
    line[0] = 1'b1;
    wait_clks(30);
    drive_frame(0, 8'hC3, 1'b0, 2'b11);
    wait_clks(10);

    // Abort an 0xFF frame halfway through data bit 4.
    line[0] = 1'b0;
    wait_clks(DIV);
    line[0] = 1'b1;
    wait_clks(DIV * 4 + HALF);
    rst = 1'b1;
    #1;
    chk("reset_midframe_outputs",
        int'({rx_data[0], rx_vld[0], rx_cerr[0], rx_ferr[0]}), 0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(120);
    chk("reset_release_outputs",
        int'({rx_data[0], rx_vld[0], rx_cerr[0], rx_ferr[0]}), 0);
    drive_frame(0, 8'h12, 1'b0, 2'b11);
    wait_clks(10);

    for (int id = 0; id < 3; id++) begin
      for (int n = 0; n < 25; n++) begin
        d   = 8'($urandom);
        par = (id == 2) ? ^d : ~^d;
        if ($urandom_range(0, 3) == 0) par = ~par;
        stp[0] = ($urandom_range(0, 3) != 0);
        stp[1] = ($urandom_range(0, 3) != 0);
        drive_frame(id, d, par, stp);
        if (stp[nstop(id) - 1] == 1'b0) begin
          line[id] = 1'b1;
          gap = $urandom_range(2, 20);
        end else begin
          gap = $urandom_range(0, 20);
        end
        if (gap > 0) wait_clks(gap);
      end
      line[id] = 1'b1;
      wait_clks(20);
    end

    wait_clks(50);
    chk("queue_drained dut0", q0.size(), 0);
    chk("queue_drained dut1", q1.size(), 0);
    chk("queue_drained dut2", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
